// File: rtl/tcb_pkg.sv
// rtl/tcb_pkg.sv - shared TCB helpers used by subordinates and interconnect
package tcb_pkg;

   // width of the alignment mask returned to callers; callers truncate to ABW
   localparam int TCB_MSK_W = 32;

   // low-address bits that must be zero for an access of 2**siz bytes
   function automatic logic [TCB_MSK_W-1:0] tcb_size_mask(input logic [7:0] siz);
      return (TCB_MSK_W'(1) << siz) - TCB_MSK_W'(1);
   endfunction

endpackage

// File: rtl/tcb_lib_delay.sv
// rtl/tcb_lib_delay.sv - DLY-stage tagged register pipeline with synchronous reset
module tcb_lib_delay #(
   parameter int DLY = 1,
   parameter int WID = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_vld,
   input  logic [WID-1:0] in_dat,
   output logic           out_vld,
   output logic [WID-1:0] out_dat
);

   // stage k holds the response that was accepted k cycles ago
   logic [DLY:1]   vld_q;
   logic [WID-1:0] dat_q [1:DLY];

   // valid tags advance every cycle so responses keep fixed latency
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
      end else begin
         vld_q[1] <= in_vld;
         for (int k = 2; k <= DLY; k++) begin
            vld_q[k] <= vld_q[k-1];
         end
      end
   end

   // data only moves with a valid tag, so the last stage holds its last response
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 1; k <= DLY; k++) begin
            dat_q[k] <= '0;
         end
      end else begin
         if (in_vld) begin
            dat_q[1] <= in_dat;
         end
         for (int k = 2; k <= DLY; k++) begin
            if (vld_q[k-1]) begin
               dat_q[k] <= dat_q[k-1];
            end
         end
      end
   end

   assign out_vld = vld_q[DLY];
   assign out_dat = dat_q[DLY];

endmodule

// File: rtl/tcb_sub_mem.sv
// rtl/tcb_sub_mem.sv - byte-addressable TCB memory subordinate with wait states
module tcb_sub_mem
   import tcb_pkg::*;
#(
   parameter  int ABW  = 32,
   parameter  int DBW  = 32,
   parameter  int SLW  = 8,
   parameter  int DLY  = 1,
   parameter  int SIZ  = 4096,
   parameter  int WAIT = 0,
   localparam int BEW  = DBW/SLW,
   localparam int SZW  = $clog2($clog2(BEW)+1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           vld,
   input  logic           wen,
   input  logic [ABW-1:0] adr,
   input  logic [SZW-1:0] siz,
   input  logic [BEW-1:0] ben,
   input  logic [DBW-1:0] wdt,
   input  logic           inc,
   input  logic           rpt,
   input  logic           lck,
   input  logic           ndn,
   output logic           rdy,
   output logic [DBW-1:0] rdt,
   output logic           err
);

   localparam int MAW = $clog2(SIZ);
   localparam int BAW = $clog2(BEW);
   localparam int WRD = SIZ/BEW;
   localparam int CNW = (WAIT > 0) ? $clog2(WAIT+1) : 1;

   if (DLY < 1) begin : g_chk_dly
      $error("tcb_sub_mem: DLY must be at least 1");
   end
   if ((SIZ & (SIZ-1)) != 0) begin : g_chk_siz
      $error("tcb_sub_mem: SIZ must be a power of two");
   end
   if (SIZ < BEW) begin : g_chk_min
      $error("tcb_sub_mem: SIZ must hold at least one word");
   end
   if (DBW != SLW*BEW) begin : g_chk_dbw
      $error("tcb_sub_mem: DBW must equal SLW*BEW");
   end

   // ------------------------------------------------------------------
   // wait-state counter: IDLE (cnt==0, ~vld), WAIT, READY (cnt==WAIT)
   // ------------------------------------------------------------------
   logic [CNW-1:0] cnt;
   logic [CNW-1:0] cnt_nxt;
   logic           trn;

   // counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_nxt;
      end
   end

   // a dropped request or a completed transfer restarts the wait
   always_comb begin
      cnt_nxt = cnt;
      if (!vld || trn) begin
         cnt_nxt = '0;
      end else begin
         cnt_nxt = cnt + CNW'(1);
      end
   end

   // ready once the programmed number of wait states has elapsed
   always_comb begin
      rdy = (cnt == CNW'(WAIT));
   end

   assign trn = vld & rdy;

   // ------------------------------------------------------------------
   // request checks
   // ------------------------------------------------------------------
   logic [ABW-1:0] siz_msk;
   logic           adr_oor;
   logic           adr_mis;
   logic           req_err;

   assign siz_msk = ABW'(tcb_size_mask(8'(siz)));
   assign adr_oor = ({1'b0, adr} >= (ABW+1)'(SIZ));
   assign adr_mis = |(adr & siz_msk);
   assign req_err = adr_oor | adr_mis;

   // ------------------------------------------------------------------
   // storage
   // ------------------------------------------------------------------
   logic [DBW-1:0]     mem [0:WRD-1];
   logic [MAW-BAW-1:0] idx;
   logic [DBW-1:0]     rd_dat;

   assign idx = adr[MAW-1:BAW];

   // lane-enabled write; erroneous writes never touch the array
   always_ff @(posedge clk) begin
      if (trn && wen && !req_err) begin
         for (int i = 0; i < BEW; i++) begin
            if (ben[i]) begin
               mem[idx][SLW*i +: SLW] <= wdt[SLW*i +: SLW];
            end
         end
      end
   end

   // read word with disabled lanes zeroed before entering the pipeline
   always_comb begin
      rd_dat = '0;
      for (int i = 0; i < BEW; i++) begin
         if (ben[i]) begin
            rd_dat[SLW*i +: SLW] = mem[idx][SLW*i +: SLW];
         end
      end
   end

   // ------------------------------------------------------------------
   // response pipelines: data advances on reads, error on every transfer
   // ------------------------------------------------------------------
   logic rdt_rsp;
   logic rsp;
   logic err_dly;

   tcb_lib_delay #(
      .DLY (DLY),
      .WID (DBW)
   ) u_dly_rdt (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (trn & ~wen),
      .in_dat  (rd_dat),
      .out_vld (rdt_rsp),
      .out_dat (rdt)
   );

   tcb_lib_delay #(
      .DLY (DLY),
      .WID (1)
   ) u_dly_err (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (trn),
      .in_dat  (req_err),
      .out_vld (rsp),
      .out_dat (err_dly)
   );

   assign err = rsp & err_dly;

   // sideband fields carry no meaning for a flat memory
   logic unused_sig;
   assign unused_sig = ^{inc, rpt, lck, ndn, rdt_rsp};

endmodule

// File: tb/tb_tcb_sub_mem.sv
// tb/tb_tcb_sub_mem.sv - scoreboard bench for tcb_sub_mem over three latency configurations
module tb_tcb_sub_mem;

   localparam int NDUT = 3;
   localparam int WAIT_T [NDUT] = '{0, 3, 2};
   localparam int DLY_T  [NDUT] = '{1, 2, 3};

   logic        clk = 1'b0;
   logic        rst    [NDUT];
   logic        vld    [NDUT];
   logic        wen    [NDUT];
   logic [31:0] adr    [NDUT];
   logic [1:0]  siz    [NDUT];
   logic [3:0]  ben    [NDUT];
   logic [31:0] wdt    [NDUT];
   logic        rdy    [NDUT];
   logic [31:0] rdt    [NDUT];
   logic        err    [NDUT];

   int cyc    = 0;
   int n_cmp  = 0;
   int n_bad  = 0;
   bit mon_en = 1'b0;

   typedef struct {
      int          dut;
      int          cyc;
      logic        err;
      logic [31:0] rdt;
      logic        chk;
   } exp_t;

   exp_t sb [$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   tcb_sub_mem #(.WAIT(0), .DLY(1)) u_dut0 (
      .clk(clk), .rst(rst[0]), .vld(vld[0]), .wen(wen[0]), .adr(adr[0]),
      .siz(siz[0]), .ben(ben[0]), .wdt(wdt[0]), .inc(1'b0), .rpt(1'b0),
      .lck(1'b0), .ndn(1'b0), .rdy(rdy[0]), .rdt(rdt[0]), .err(err[0])
   );

   tcb_sub_mem #(.WAIT(3), .DLY(2)) u_dut1 (
      .clk(clk), .rst(rst[1]), .vld(vld[1]), .wen(wen[1]), .adr(adr[1]),
      .siz(siz[1]), .ben(ben[1]), .wdt(wdt[1]), .inc(1'b0), .rpt(1'b0),
      .lck(1'b0), .ndn(1'b0), .rdy(rdy[1]), .rdt(rdt[1]), .err(err[1])
   );

   tcb_sub_mem #(.WAIT(2), .DLY(3)) u_dut2 (
      .clk(clk), .rst(rst[2]), .vld(vld[2]), .wen(wen[2]), .adr(adr[2]),
      .siz(siz[2]), .ben(ben[2]), .wdt(wdt[2]), .inc(1'b0), .rpt(1'b0),
      .lck(1'b0), .ndn(1'b0), .rdy(rdy[2]), .rdt(rdt[2]), .err(err[2])
   );

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // issue one request and hold it until accepted; expected response goes to the scoreboard
   task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [1:0] s,
                       input logic [3:0] b, input logic [31:0] wd, input logic e_err,
                       input logic [31:0] e_rdt, input logic e_chk, input int e_wait,
                       output int t_cyc);
      int   n;
      exp_t e;
      @(negedge clk);
      vld[d] = 1'b1; wen[d] = w; adr[d] = a; siz[d] = s; ben[d] = b; wdt[d] = wd;
      #1;
      n = 0;
      while (!rdy[d] && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      t_cyc = -1;
      if (!rdy[d]) begin
         cmp($sformatf("rdy timeout d%0d adr %h", d, a), 32'(rdy[d]), 32'd1);
      end else begin
         cmp($sformatf("wait d%0d adr %h", d, a), 32'(n), 32'(e_wait));
         e.dut = d; e.cyc = cyc + DLY_T[d]; e.err = e_err; e.rdt = e_rdt; e.chk = e_chk;
         sb.push_back(e);
         t_cyc = cyc;
      end
   endtask

   task automatic idle(input int d);
      @(negedge clk);
      vld[d] = 1'b0;
   endtask

   // monitor: every response cycle is matched against the scoreboard, others must show err=0
   always @(negedge clk) begin
      if (mon_en) begin
         for (int d = 0; d < NDUT; d++) begin
            int hit;
            hit = -1;
            for (int i = 0; i < sb.size(); i++) begin
               if (sb[i].dut == d && sb[i].cyc == cyc) hit = i;
            end
            if (hit >= 0) begin
               cmp($sformatf("rsp err d%0d", d), 32'(err[d]), 32'(sb[hit].err));
               if (sb[hit].chk) begin
                  cmp($sformatf("rsp rdt d%0d", d), rdt[d], sb[hit].rdt);
               end
               sb.delete(hit);
            end else begin
               cmp($sformatf("idle err d%0d", d), 32'(err[d]), 32'd0);
            end
         end
      end
   end

   initial begin
      int t, t1, t2, n;
      for (int d = 0; d < NDUT; d++) begin
         rst[d] = 1'b1; vld[d] = 1'b0; wen[d] = 1'b0; adr[d] = '0;
         siz[d] = 2'd2; ben[d] = 4'hF; wdt[d] = '0;
      end
      repeat (2) @(negedge clk);
      #1;
      for (int d = 0; d < NDUT; d++) begin
         cmp($sformatf("reset rdy d%0d", d), 32'(rdy[d]), (WAIT_T[d] == 0) ? 32'd1 : 32'd0);
         cmp($sformatf("reset rdt d%0d", d), rdt[d], 32'd0);
         cmp($sformatf("reset err d%0d", d), 32'(err[d]), 32'd0);
      end
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) rst[d] = 1'b0;
      mon_en = 1'b1;

      // WAIT=0, DLY=1: functional checks
      xfer(0, 1, 32'h0000, 2, 4'hF, 32'hA5A5A5A5, 0, 32'h0, 0, 0, t);
      xfer(0, 1, 32'h0010, 2, 4'hF, 32'hDEADBEEF, 0, 32'h0, 0, 0, t);
      xfer(0, 0, 32'h0010, 2, 4'hF, 32'h0,        0, 32'hDEADBEEF, 1, 0, t);
      xfer(0, 1, 32'h0020, 2, 4'hF, 32'h11223344, 0, 32'h0, 0, 0, t);
      xfer(0, 1, 32'h0020, 2, 4'b0010, 32'h0000AB00, 0, 32'h0, 0, 0, t);
      xfer(0, 0, 32'h0020, 2, 4'hF, 32'h0,        0, 32'h1122AB44, 1, 0, t);
      xfer(0, 0, 32'h1000, 2, 4'hF, 32'h0,        1, 32'h0, 0, 0, t);
      xfer(0, 1, 32'h1000, 2, 4'hF, 32'h12345678, 1, 32'h0, 0, 0, t);
      xfer(0, 0, 32'h0000, 2, 4'hF, 32'h0,        0, 32'hA5A5A5A5, 1, 0, t);
      xfer(0, 0, 32'h0002, 2, 4'hF, 32'h0,        1, 32'h0, 0, 0, t);
      xfer(0, 0, 32'h0002, 1, 4'b1100, 32'h0,     0, 32'hA5A50000, 1, 0, t);
      xfer(0, 1, 32'h0012, 2, 4'hF, 32'h0,        1, 32'h0, 0, 0, t);
      xfer(0, 0, 32'h0010, 2, 4'b0101, 32'h0,     0, 32'h00AD00EF, 1, 0, t);
      xfer(0, 0, 32'h0003, 0, 4'b1000, 32'h0,     0, 32'hA5000000, 1, 0, t);
      idle(0);

      // WAIT=3, DLY=2: fresh and back-to-back acceptance latency
      xfer(1, 1, 32'h0008, 2, 4'hF, 32'h0BADF00D, 0, 32'h0, 0, 3, t);
      idle(1);
      xfer(1, 0, 32'h0008, 2, 4'hF, 32'h0,        0, 32'h0BADF00D, 1, 3, t1);
      xfer(1, 0, 32'h0008, 2, 4'b0011, 32'h0,     0, 32'h0000F00D, 1, 3, t2);
      cmp("b2b spacing", 32'(t2 - t1), 32'd4);
      idle(1);
      // request withdrawn mid-wait restarts the count
      @(negedge clk);
      vld[1] = 1'b1; wen[1] = 1'b0; adr[1] = 32'h8; ben[1] = 4'hF;
      repeat (2) @(negedge clk);
      #1;
      cmp("withdraw rdy", 32'(rdy[1]), 32'd0);
      vld[1] = 1'b0;
      xfer(1, 0, 32'h0008, 2, 4'hF, 32'h0,        0, 32'h0BADF00D, 1, 3, t);
      idle(1);

      // WAIT=2, DLY=3: reset mid-wait with a read in flight
      xfer(2, 1, 32'h0040, 2, 4'hF, 32'h00000055, 0, 32'h0, 0, 2, t);
      xfer(2, 1, 32'h0044, 2, 4'hF, 32'hCAFEF00D, 0, 32'h0, 0, 2, t);
      xfer(2, 0, 32'h0040, 2, 4'hF, 32'h0,        0, 32'h00000055, 1, 2, t);
      @(negedge clk);
      adr[2] = 32'h44;
      #1;
      cmp("rst seq rdy cnt0", 32'(rdy[2]), 32'd0);
      @(negedge clk);
      rst[2] = 1'b1;
      #1;
      cmp("rst seq rdy cnt1", 32'(rdy[2]), 32'd0);
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].dut == 2) sb.delete(i);
      end
      @(negedge clk);
      rst[2] = 1'b0;
      #1;
      cmp("post rst rdy 1", 32'(rdy[2]), 32'd0);
      cmp("post rst rdt 1", rdt[2], 32'd0);
      cmp("post rst err 1", 32'(err[2]), 32'd0);
      @(negedge clk);
      #1;
      cmp("post rst rdy 2", 32'(rdy[2]), 32'd0);
      cmp("post rst rdt 2", rdt[2], 32'd0);
      @(negedge clk);
      #1;
      cmp("post rst rdy 3", 32'(rdy[2]), 32'd1);
      begin
         exp_t e;
         e.dut = 2; e.cyc = cyc + DLY_T[2]; e.err = 1'b0; e.rdt = 32'hCAFEF00D; e.chk = 1'b1;
         sb.push_back(e);
      end
      idle(2);

      // drain outstanding responses
      n = 0;
      while (sb.size() > 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      cmp("scoreboard drained", 32'(sb.size()), 32'd0);
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
